// File: rtl/seq_divider_1.sv
// ---------------------------------------------------------------------------
// seq_divider_1
// Sequential signed restoring divider. It divides a DIVIDEND_W-bit
// two's-complement dividend by a DIVISOR_W-bit two's-complement divisor,
// producing one quotient bit per clock, MSB first.
//
// It uses the same en / result_rdy handshake as booth_top_1, so one
// controller can drive both blocks in the same way.
//
// Optional build macro: DIV_ROUND_EN
//   When it is defined, the quotient is rounded to nearest, with ties
//   rounded away from zero. The remainder is then dividend - quotient*divisor.
//   When it is undefined, the quotient is truncated toward zero and no
//   rounding logic is built.
// ---------------------------------------------------------------------------
module seq_divider_1 #(
    parameter int DIVIDEND_W = 24,
    parameter int DIVISOR_W  = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  result_rdy,
    output logic                  busy,
    output logic                  div_by_zero
);

    // Control states: capture, magnitude setup, shift/subtract, sign fix-up
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        SIGN = 2'd3
    } state_t;

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    // Magnitude limits, held in DIVIDEND_W+1 bits so that 2^(DIVIDEND_W-1)
    // can be represented.
    localparam logic [DIVIDEND_W:0] MAX_POS_MAG = {2'b00, {(DIVIDEND_W-1){1'b1}}};
    localparam logic [DIVIDEND_W:0] MIN_NEG_MAG = {2'b01, {(DIVIDEND_W-1){1'b0}}};

    // Saturated two's-complement quotient values
    localparam logic [DIVIDEND_W-1:0] MAX_POS = {1'b0, {(DIVIDEND_W-1){1'b1}}};
    localparam logic [DIVIDEND_W-1:0] MIN_NEG = {1'b1, {(DIVIDEND_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                state_q,       state_d;
    logic [DIVIDEND_W-1:0] dvd_in_q,      dvd_in_d;
    logic [DIVISOR_W-1:0]  dsr_in_q,      dsr_in_d;
    logic [DIVIDEND_W:0]   dvd_mag_q,     dvd_mag_d;
    logic [DIVISOR_W:0]    dsr_mag_q,     dsr_mag_d;
    logic [DIVISOR_W:0]    rem_q,         rem_d;
    logic [DIVIDEND_W:0]   quo_mag_q,     quo_mag_d;
    logic                  dvd_neg_q,     dvd_neg_d;
    logic                  dsr_neg_q,     dsr_neg_d;
    logic                  dz_q,          dz_d;
    logic [CNT_W-1:0]      cnt_q,         cnt_d;
    logic [DIVIDEND_W-1:0] quotient_q,    quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q,   remainder_d;
    logic                  result_rdy_q,  result_rdy_d;
    logic                  busy_q,        busy_d;
    logic                  div_by_zero_q, div_by_zero_d;

    // ------------------------------------------------------------------
    // Magnitude conversion of the captured operands (used in LOAD)
    // ------------------------------------------------------------------
    logic [DIVIDEND_W:0] dvd_ext;
    logic [DIVIDEND_W:0] dvd_abs;
    logic [DIVISOR_W:0]  dsr_ext;
    logic [DIVISOR_W:0]  dsr_abs;
    logic                dsr_is_zero;

    assign dvd_ext     = {dvd_in_q[DIVIDEND_W-1], dvd_in_q};
    assign dvd_abs     = dvd_ext[DIVIDEND_W] ? -dvd_ext : dvd_ext;
    assign dsr_ext     = {dsr_in_q[DIVISOR_W-1], dsr_in_q};
    assign dsr_abs     = dsr_ext[DIVISOR_W] ? -dsr_ext : dsr_ext;
    assign dsr_is_zero = (dsr_in_q == '0);

    // ------------------------------------------------------------------
    // One restoring step: bring down the next dividend bit, then subtract
    // the divisor if the trial remainder is large enough. The partial
    // remainder is always below |divisor|, so the shifted value fits in
    // DIVISOR_W+1 bits.
    // ------------------------------------------------------------------
    logic [DIVISOR_W:0] trial;
    logic               take;

    assign trial = (rem_q << 1) | {{DIVISOR_W{1'b0}}, dvd_mag_q[DIVIDEND_W-1]};
    assign take  = (trial >= dsr_mag_q);

    // ------------------------------------------------------------------
    // Final result formation (used in SIGN)
    // ------------------------------------------------------------------
    logic [DIVIDEND_W:0]   q_mag_fin;
    logic [DIVISOR_W:0]    r_mag_fin;
    logic                  r_neg_fin;
    logic                  q_neg;
    logic                  q_sat;
    logic [DIVIDEND_W-1:0] fin_quotient;
    logic [DIVISOR_W-1:0]  fin_remainder;

    // Apply the sign rules, optional rounding and saturation to the unsigned iteration results
    always_comb begin
        q_mag_fin     = quo_mag_q;
        r_mag_fin     = rem_q;
        r_neg_fin     = dvd_neg_q;
        q_neg         = dvd_neg_q ^ dsr_neg_q;
        q_sat         = 1'b0;
        fin_quotient  = '0;
        fin_remainder = '0;

`ifdef DIV_ROUND_EN
        // Round half away from zero. The remainder then moves to the other
        // side of zero with magnitude |divisor| - |rem|.
        if ((rem_q << 1) >= dsr_mag_q) begin
            q_mag_fin = quo_mag_q + {{DIVIDEND_W{1'b0}}, 1'b1};
            r_mag_fin = dsr_mag_q - rem_q;
            r_neg_fin = ~dvd_neg_q;
        end
`endif

        if (q_neg) begin
            q_sat = (q_mag_fin > MIN_NEG_MAG);
        end else begin
            q_sat = (q_mag_fin > MAX_POS_MAG);
        end

        if (dz_q) begin
            fin_quotient  = dvd_neg_q ? MIN_NEG : MAX_POS;
            fin_remainder = '0;
        end else if (q_sat) begin
            fin_quotient  = q_neg ? MIN_NEG : MAX_POS;
            fin_remainder = '0;
        end else begin
            fin_quotient  = DIVIDEND_W'(q_neg ? -q_mag_fin : q_mag_fin);
            fin_remainder = DIVISOR_W'(r_neg_fin ? -r_mag_fin : r_mag_fin);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    // Sequence IDLE -> LOAD -> ITER x DIVIDEND_W -> SIGN, with LOAD going straight to SIGN on a zero divisor
    always_comb begin
        state_d       = state_q;
        dvd_in_d      = dvd_in_q;
        dsr_in_d      = dsr_in_q;
        dvd_mag_d     = dvd_mag_q;
        dsr_mag_d     = dsr_mag_q;
        rem_d         = rem_q;
        quo_mag_d     = quo_mag_q;
        dvd_neg_d     = dvd_neg_q;
        dsr_neg_d     = dsr_neg_q;
        dz_d          = dz_q;
        cnt_d         = cnt_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        result_rdy_d  = 1'b0;
        busy_d        = busy_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    dvd_in_d = dividend;
                    dsr_in_d = divisor;
                    busy_d   = 1'b1;
                    state_d  = LOAD;
                end
            end

            LOAD: begin
                dvd_neg_d = dvd_in_q[DIVIDEND_W-1];
                dsr_neg_d = dsr_in_q[DIVISOR_W-1];
                dvd_mag_d = dvd_abs;
                dsr_mag_d = dsr_abs;
                if (dsr_is_zero) begin
                    dz_d    = 1'b1;
                    state_d = SIGN;
                end else begin
                    dz_d      = 1'b0;
                    rem_d     = '0;
                    quo_mag_d = '0;
                    cnt_d     = CNT_W'(DIVIDEND_W - 1);
                    state_d   = ITER;
                end
            end

            ITER: begin
                rem_d     = take ? (trial - dsr_mag_q) : trial;
                quo_mag_d = (quo_mag_q << 1) | {{DIVIDEND_W{1'b0}}, take};
                dvd_mag_d = dvd_mag_q << 1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = SIGN;
                end
            end

            SIGN: begin
                quotient_d    = fin_quotient;
                remainder_d   = fin_remainder;
                div_by_zero_d = dz_q;
                result_rdy_d  = 1'b1;
                busy_d        = 1'b0;
                state_d       = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers; an asynchronous reset aborts any division in progress
    // ------------------------------------------------------------------
    // Update all state and datapath flops; reset clears them immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dvd_in_q      <= '0;
            dsr_in_q      <= '0;
            dvd_mag_q     <= '0;
            dsr_mag_q     <= '0;
            rem_q         <= '0;
            quo_mag_q     <= '0;
            dvd_neg_q     <= 1'b0;
            dsr_neg_q     <= 1'b0;
            dz_q          <= 1'b0;
            cnt_q         <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            result_rdy_q  <= 1'b0;
            busy_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dvd_in_q      <= dvd_in_d;
            dsr_in_q      <= dsr_in_d;
            dvd_mag_q     <= dvd_mag_d;
            dsr_mag_q     <= dsr_mag_d;
            rem_q         <= rem_d;
            quo_mag_q     <= quo_mag_d;
            dvd_neg_q     <= dvd_neg_d;
            dsr_neg_q     <= dsr_neg_d;
            dz_q          <= dz_d;
            cnt_q         <= cnt_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            result_rdy_q  <= result_rdy_d;
            busy_q        <= busy_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign result_rdy  = result_rdy_q;
    assign busy        = busy_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider_1.sv
// ---------------------------------------------------------------------------
// tb_seq_divider_1
// Self-checking bench for seq_divider_1. It compares every result against a
// reference model that uses plain integer division together with the
// saturation and divide-by-zero rules. When DIV_ROUND_EN is defined, the
// model also applies round-half-away-from-zero.
// ---------------------------------------------------------------------------
module tb_seq_divider_1;

    localparam int DW = 24;
    localparam int SW = 12;
    localparam longint MAXQ = (longint'(1) << (DW - 1)) - 1;
    localparam longint MINQ = -(longint'(1) << (DW - 1));

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] dividend;
    logic [SW-1:0] divisor;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          result_rdy;
    logic          busy;
    logic          div_by_zero;

    int checks    = 0;
    int errors    = 0;
    int cycle_cnt = 0;
    int t0        = 0;

    logic [DW-1:0] prev_q;
    logic [SW-1:0] prev_r;
    logic          prev_dz;

    seq_divider_1 #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .result_rdy  (result_rdy),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used for latency measurements
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Reference model: truncating signed division with saturation and divide-by-zero rules
    function automatic void refModel(input longint a, input longint b,
                                     output logic [DW-1:0] q, output logic [SW-1:0] r,
                                     output logic dz);
        longint qi;
        longint ri;
        if (b == 0) begin
            qi = (a >= 0) ? MAXQ : MINQ;
            ri = 0;
            dz = 1'b1;
        end else begin
            qi = a / b;
            ri = a % b;
            dz = 1'b0;
`ifdef DIV_ROUND_EN
            begin
                longint abs_r;
                longint abs_b;
                abs_r = (ri < 0) ? -ri : ri;
                abs_b = (b < 0) ? -b : b;
                if (2 * abs_r >= abs_b) begin
                    qi = qi + ((((a < 0) != (b < 0))) ? -1 : 1);
                    ri = a - qi * b;
                end
            end
`endif
            if (qi > MAXQ) begin
                qi = MAXQ;
                ri = 0;
            end else if (qi < MINQ) begin
                qi = MINQ;
                ri = 0;
            end
        end
        q = qi[DW-1:0];
        r = ri[SW-1:0];
    endfunction

    // Single comparison point: count it and report any difference
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start an operation, return just after the start edge, then scramble the inputs
    task automatic applyStimulus(input longint a, input longint b);
        @(negedge clk);
        en       = 1'b1;
        dividend = DW'(a);
        divisor  = SW'(b);
        @(posedge clk);
        #1;
        t0 = cycle_cnt;
        @(negedge clk);
        en       = 1'b0;
        dividend = DW'($urandom);
        divisor  = SW'($urandom);
    endtask

    // Wait, with a bound, for result_rdy; latency is counted in edges from the start edge
    task automatic waitResult(output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (result_rdy) begin
                lat = cycle_cnt - t0;
                break;
            end
        end
    endtask

    // One complete division with hold, latency, result and pulse-width checks
    task automatic runDivision(input string tag, input longint a, input longint b);
        logic [DW-1:0] eq;
        logic [SW-1:0] er;
        logic          ed;
        int            lat;
        refModel(a, b, eq, er, ed);
        applyStimulus(a, b);
        checkOutput({tag, ".busy"}, 64'(busy), 64'(1));
        checkOutput({tag, ".hold_q"}, 64'(quotient), 64'(prev_q));
        checkOutput({tag, ".hold_dz"}, 64'(div_by_zero), 64'(prev_dz));
        waitResult(lat);
        checkOutput({tag, ".latency"}, 64'(lat), 64'((b == 0) ? 2 : DW + 2));
        checkOutput({tag, ".q"}, 64'(quotient), 64'(eq));
        checkOutput({tag, ".r"}, 64'(remainder), 64'(er));
        checkOutput({tag, ".dz"}, 64'(div_by_zero), 64'(ed));
        checkOutput({tag, ".busy_at_rdy"}, 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        checkOutput({tag, ".rdy_pulse"}, 64'(result_rdy), 64'(0));
        checkOutput({tag, ".q_held"}, 64'(quotient), 64'(eq));
        prev_q  = eq;
        prev_r  = er;
        prev_dz = ed;
    endtask

    initial begin : stimulus
        longint        da [12];
        longint        db [12];
        logic [DW-1:0] eq;
        logic [SW-1:0] er;
        logic          ed;
        logic [DW-1:0] rd;
        logic [SW-1:0] rs;
        longint        a;
        longint        b;
        int            lat;
        int            seen;

        da = '{1000, -1000, 1000, -1000, 5, -5, 9, -8388608, -8388608, 8388607, 8388607, -8388608};
        db = '{7, 7, -7, -7, 0, 0, 3, -1, -2048, -2048, 1, 1};

        // Reset state
        rst_n    = 1'b0;
        en       = 1'b0;
        dividend = '0;
        divisor  = '0;
        prev_q   = '0;
        prev_r   = '0;
        prev_dz  = 1'b0;
        #12;
        checkOutput("reset.q", 64'(quotient), 64'(0));
        checkOutput("reset.r", 64'(remainder), 64'(0));
        checkOutput("reset.rdy", 64'(result_rdy), 64'(0));
        checkOutput("reset.busy", 64'(busy), 64'(0));
        checkOutput("reset.dz", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases, including sign combinations, zero divisor and overflow
        for (int i = 0; i < 12; i++) begin
            runDivision($sformatf("dir%0d", i), da[i], db[i]);
        end

        // Random operands checked against the reference model
        for (int i = 0; i < 40; i++) begin
            rd = DW'($urandom);
            if ($urandom_range(0, 3) == 0) rd = DW'($urandom_range(0, 4000));
            rs = SW'($urandom);
            if ($urandom_range(0, 2) == 0) rs = SW'($urandom_range(0, 32)) - SW'(16);
            a = $signed(rd);
            b = $signed(rs);
            runDivision($sformatf("rand%0d", i), a, b);
        end

        // en pulsed while busy is ignored
        refModel(1000, 7, eq, er, ed);
        applyStimulus(1000, 7);
        repeat (9) @(negedge clk);
        en       = 1'b1;
        dividend = DW'(50);
        divisor  = SW'(5);
        @(negedge clk);
        en = 1'b0;
        waitResult(lat);
        checkOutput("busy_ign.latency", 64'(lat), 64'(DW + 2));
        checkOutput("busy_ign.q", 64'(quotient), 64'(eq));
        checkOutput("busy_ign.r", 64'(remainder), 64'(er));
        @(posedge clk);
        #1;
        checkOutput("busy_ign.rdy_pulse", 64'(result_rdy), 64'(0));
        checkOutput("busy_ign.no_restart", 64'(busy), 64'(0));

        // en held high: back-to-back operation
        @(negedge clk);
        en       = 1'b1;
        dividend = DW'(1000);
        divisor  = SW'(7);
        @(posedge clk);
        #1;
        t0 = cycle_cnt;
        @(negedge clk);
        dividend = DW'(50);
        divisor  = SW'(5);
        waitResult(lat);
        checkOutput("b2b.first_latency", 64'(lat), 64'(DW + 2));
        checkOutput("b2b.first_q", 64'(quotient), 64'(eq));
        t0 = cycle_cnt;
        refModel(50, 5, eq, er, ed);
        waitResult(lat);
        checkOutput("b2b.second_gap", 64'(lat), 64'(DW + 3));
        checkOutput("b2b.second_q", 64'(quotient), 64'(eq));
        checkOutput("b2b.second_r", 64'(remainder), 64'(er));
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("b2b.stopped", 64'(busy), 64'(0));

        // Asynchronous reset during a division aborts it
        applyStimulus(1000, 7);
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort.q", 64'(quotient), 64'(0));
        checkOutput("abort.r", 64'(remainder), 64'(0));
        checkOutput("abort.rdy", 64'(result_rdy), 64'(0));
        checkOutput("abort.busy", 64'(busy), 64'(0));
        checkOutput("abort.dz", 64'(div_by_zero), 64'(0));
        prev_q  = '0;
        prev_r  = '0;
        prev_dz = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (result_rdy) seen++;
        end
        checkOutput("abort.no_rdy", 64'(seen), 64'(0));
        runDivision("after_reset", 21, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
